// File: rtl/ss_tr_stack_if.sv
// Bundled control, source and status signals between the control unit and the
// temporary-register stack.
interface ss_tr_stack_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NSRC  = 8
);
  localparam int unsigned SELW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [SELW-1:0]       tr_src;
  logic                  tr_write;
  logic                  tr_push;
  logic                  tr_pop;
  logic                  clr_err;
  logic [WIDTH-1:0]      tr;
  logic [WIDTH-1:0]      tr_next;
  logic [CNTW-1:0]       count;
  logic                  full;
  logic                  empty;
  logic                  ovf;
  logic                  unf;

  modport master (
    output src_data, tr_src, tr_write, tr_push, tr_pop, clr_err,
    input  tr, tr_next, count, full, empty, ovf, unf
  );

  modport slave (
    input  src_data, tr_src, tr_write, tr_push, tr_pop, clr_err,
    output tr, tr_next, count, full, empty, ovf, unf
  );
endinterface

// File: rtl/ss_tr_stack.sv
// DEPTH-entry LIFO of temporary registers fed from an NSRC-way source mux, with
// push/pop/overwrite/replace commands, occupancy status and sticky error flags.
module ss_tr_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NSRC  = 8
) (
  input  logic           CLK,
  input  logic           reset,
  ss_tr_stack_if.slave   bus
);
  localparam int unsigned SELW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_depth_chk
    $error("ss_tr_stack: DEPTH must be at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNTW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] sel_val;
  logic             is_empty, is_full;
  logic             ovf_set, unf_set;
  logic [IDXW-1:0]  top_idx, push_idx, next_idx;

  // Source mux; an out-of-range select yields zero.
  always_comb begin
    sel_val = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (bus.tr_src == SELW'(k)) sel_val = bus.src_data[k*WIDTH +: WIDTH];
    end
  end

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNTW'(DEPTH));
  assign top_idx  = IDXW'(count_q - CNTW'(1));
  assign push_idx = IDXW'(count_q);
  assign next_idx = IDXW'(count_q - CNTW'(2));

  // Command decode: replace > push > pop > write.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.tr_push && bus.tr_pop) begin
      if (is_empty) begin
        mem_d[0] = sel_val;
        count_d  = CNTW'(1);
      end else begin
        mem_d[top_idx] = sel_val;
      end
    end else if (bus.tr_push) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        mem_d[push_idx] = sel_val;
        count_d         = count_q + CNTW'(1);
      end
    end else if (bus.tr_pop) begin
      if (is_empty) unf_set = 1'b1;
      else          count_d = count_q - CNTW'(1);
    end else if (bus.tr_write) begin
      if (is_empty) unf_set = 1'b1;
      else          mem_d[top_idx] = sel_val;
    end
    // A new error in the clearing cycle keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
    unf_d = unf_set | (unf_q & ~bus.clr_err);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Views are gated by occupancy so stale popped slots never leak out.
  assign bus.tr      = is_empty ? '0 : mem_q[top_idx];
  assign bus.tr_next = (count_q >= CNTW'(2)) ? mem_q[next_idx] : '0;
  assign bus.count   = count_q;
  assign bus.full    = is_full;
  assign bus.empty   = is_empty;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
endmodule

// File: tb/tb_ss_tr_stack.sv
// Directed-vector bench for ss_tr_stack (WIDTH=16, DEPTH=8, NSRC=5).
module tb_ss_tr_stack;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NSRC  = 5;

  typedef struct {
    logic        push, pop, wr, clr;
    logic [2:0]  sel;
    logic [15:0] val;
    logic [15:0] e_tr, e_next;
    logic [3:0]  e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ss_tr_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NSRC(NSRC)) bus();
  ss_tr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
    .CLK(clk), .reset(reset), .bus(bus)
  );

  task automatic add(input logic push, pop, wr, clr, input logic [2:0] sel,
                     input logic [15:0] val, e_tr, e_next, input logic [3:0] e_cnt,
                     input logic e_ovf, e_unf);
    vec_t v;
    v.push = push; v.pop = pop; v.wr = wr; v.clr = clr; v.sel = sel; v.val = val;
    v.e_tr = e_tr; v.e_next = e_next; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endtask

  // Sources 0,1,2,4 are fixed; source 3 carries the per-vector value.
  task automatic drive(input logic push, pop, wr, clr, input logic [2:0] sel,
                       input logic [15:0] val);
    bus.tr_push  = push;
    bus.tr_pop   = pop;
    bus.tr_write = wr;
    bus.clr_err  = clr;
    bus.tr_src   = sel;
    bus.src_data = {16'h4444, val, 16'h3333, 16'h2222, 16'h1111};
  endtask

  task automatic check(input string name, input logic [15:0] e_tr, e_next,
                       input logic [3:0] e_cnt, input logic e_ovf, e_unf);
    logic [39:0] act, exp;
    act = {bus.tr, bus.tr_next, bus.count, bus.full, bus.empty, bus.ovf, bus.unf};
    exp = {e_tr, e_next, e_cnt, (e_cnt == 4'd8), (e_cnt == 4'd0), e_ovf, e_unf};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got tr=%h next=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b, want tr=%h next=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b",
               name, act[39:24], act[23:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[39:24], exp[23:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // push/pop order
    add(1,0,0,0, 3'd0, 16'h0, 16'h1111, 16'h0000, 4'd1, 0, 0);
    add(1,0,0,0, 3'd1, 16'h0, 16'h2222, 16'h1111, 4'd2, 0, 0);
    add(1,0,0,0, 3'd2, 16'h0, 16'h3333, 16'h2222, 4'd3, 0, 0);
    add(0,1,0,0, 3'd0, 16'h0, 16'h2222, 16'h1111, 4'd2, 0, 0);
    add(0,1,0,0, 3'd0, 16'h0, 16'h1111, 16'h0000, 4'd1, 0, 0);
    add(0,1,0,0, 3'd0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 0);
    // underflow and clear-vs-set
    add(0,1,0,0, 3'd0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 1);
    add(0,0,0,1, 3'd0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 0);
    add(0,0,1,0, 3'd0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 1);
    add(0,1,0,1, 3'd0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 1);
    add(0,0,0,1, 3'd0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 0);
    // replace on empty acts as push without underflow
    add(1,1,0,0, 3'd0, 16'h0, 16'h1111, 16'h0000, 4'd1, 0, 0);
    add(0,1,0,0, 3'd0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 0);
    // fill to full, then overflow
    for (int k = 1; k <= 8; k++)
      add(1,0,0,0, 3'd3, 16'(k), 16'(k), 16'(k-1), 4'(k), 0, 0);
    add(1,0,0,0, 3'd3, 16'hFFFF, 16'h0008, 16'h0007, 4'd8, 1, 0);
    add(0,0,0,1, 3'd0, 16'h0,    16'h0008, 16'h0007, 4'd8, 0, 0);
    add(1,0,0,1, 3'd3, 16'hFFFF, 16'h0008, 16'h0007, 4'd8, 1, 0);
    add(0,0,0,1, 3'd0, 16'h0,    16'h0008, 16'h0007, 4'd8, 0, 0);
    add(0,0,1,0, 3'd3, 16'h0088, 16'h0088, 16'h0007, 4'd8, 0, 0);
    // drain; popped slots must not be visible
    for (int j = 1; j <= 8; j++)
      add(0,1,0,0, 3'd0, 16'h0, 16'(8-j), (j < 7) ? 16'(7-j) : 16'h0, 4'(8-j), 0, 0);
    // replace / overwrite priority
    add(1,0,0,0, 3'd3, 16'h00AA, 16'h00AA, 16'h0000, 4'd1, 0, 0);
    add(1,0,0,0, 3'd3, 16'h00BB, 16'h00BB, 16'h00AA, 4'd2, 0, 0);
    add(1,1,0,0, 3'd3, 16'hCCCC, 16'hCCCC, 16'h00AA, 4'd2, 0, 0);
    add(1,0,1,0, 3'd3, 16'hDDDD, 16'hDDDD, 16'hCCCC, 4'd3, 0, 0);
    // out-of-range select pushes zero
    add(1,0,0,0, 3'd6, 16'h0, 16'h0000, 16'hDDDD, 4'd4, 0, 0);
    add(0,0,1,0, 3'd4, 16'h0, 16'h4444, 16'hDDDD, 4'd4, 0, 0);
    add(0,1,0,0, 3'd0, 16'h0, 16'hDDDD, 16'hCCCC, 4'd3, 0, 0);
    add(0,1,1,0, 3'd0, 16'h0, 16'hCCCC, 16'h00AA, 4'd2, 0, 0);
    add(0,0,0,0, 3'd0, 16'h0, 16'hCCCC, 16'h00AA, 4'd2, 0, 0);

    reset = 1'b0;
    drive(0,0,0,0, 3'd0, 16'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_defaults", 16'h0, 16'h0, 4'd0, 0, 0);
    @(negedge clk) reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].push, vecs[i].pop, vecs[i].wr, vecs[i].clr, vecs[i].sel, vecs[i].val);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].e_tr, vecs[i].e_next, vecs[i].e_cnt,
               vecs[i].e_ovf, vecs[i].e_unf);
    end

    // asynchronous reset mid-cycle with a push in flight
    @(negedge clk) drive(1,0,0,0, 3'd0, 16'h0);
    @(posedge clk);
    #1 check("push_before_reset", 16'h1111, 16'hCCCC, 4'd3, 0, 0);
    #2 reset = 1'b0;
    #1 check("async_reset_immediate", 16'h0, 16'h0, 4'd0, 0, 0);
    @(posedge clk);
    #1 check("reset_held_push", 16'h0, 16'h0, 4'd0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0,0,0,0, 3'd0, 16'h0);
    @(posedge clk);
    #1 check("after_release_idle", 16'h0, 16'h0, 4'd0, 0, 0);
    @(negedge clk) drive(1,0,0,0, 3'd1, 16'h0);
    @(posedge clk);
    #1 check("push_after_reset", 16'h2222, 16'h0, 4'd1, 0, 0);
    @(negedge clk) drive(0,0,0,0, 3'd0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
